mem_arbiter: RTL

- Shares one single-ported, variable-latency unified memory between the instruction-fetch port (IF stage) and the data port (MEM stage).
- Grants one requester at a time and drives the memory handshake.
- Returns read data with a one-cycle ready pulse.
- Generates the stall requests that the hazard unit combines into stall_f / stall_d / stall_e.

---
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, variable-latency unified memory
// between the instruction-fetch port and the data port.
//   clk, reset           : clock, async active-high reset
//   if_req/if_addr       : fetch request (held until if_ready)
//   if_rdata/if_ready    : fetched word + one-cycle completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata/dm_wstrb : data request (held until dm_ready)
//   dm_rdata/dm_ready    : load data + one-cycle completion pulse
//   mem_valid/mem_we/mem_addr/mem_wdata/mem_wstrb : memory request
//   mem_rdata/mem_ready  : memory response
//   stall_if/stall_mem   : stall requests for the hazard unit
//   bus_err              : one-cycle pulse when an access times out
module mem_arbiter #(
  parameter int          ADDR_W         = 32,
  parameter int          TIMEOUT        = 16,
  parameter int          STARVE_MAX     = 4,
  parameter logic [31:0] FETCH_ERR_DATA = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  input  logic [3:0]        dm_wstrb,
  output logic [31:0]       dm_rdata,
  output logic              dm_ready,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              bus_err
);

  localparam int TO_W = $clog2(TIMEOUT);
  localparam int ST_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DATA, S_RESP} state_e;

  state_e            state_q, state_d;
  logic              gnt_if_q, gnt_if_d;   // 1: current access belongs to fetch
  logic              err_q, err_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [ST_W-1:0]   starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       dm_rdata_q, dm_rdata_d;

  logic force_fetch;
  assign force_fetch = (starve_q == ST_W'(STARVE_MAX)) && if_req;

  always_comb begin
    state_d    = state_q;
    gnt_if_d   = gnt_if_q;
    err_d      = err_q;
    to_d       = to_q;
    starve_d   = starve_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    case (state_q)
      S_IDLE: begin
        err_d = 1'b0;
        if (dm_req && !force_fetch) begin
          state_d  = S_DATA;
          gnt_if_d = 1'b0;
          to_d     = '0;
          addr_d   = dm_addr;
          we_d     = dm_we;
          wdata_d  = dm_wdata;
          wstrb_d  = dm_we ? dm_wstrb : 4'h0;
          // Count data grants that bypass a waiting fetch; saturating.
          if (!if_req)                             starve_d = '0;
          else if (starve_q != ST_W'(STARVE_MAX)) starve_d = starve_q + 1'b1;
        end else if (if_req) begin
          state_d  = S_FETCH;
          gnt_if_d = 1'b1;
          to_d     = '0;
          starve_d = '0;
          addr_d   = if_addr;
          we_d     = 1'b0;
          wdata_d  = '0;
          wstrb_d  = 4'h0;
        end
      end
      S_FETCH, S_DATA: begin
        if (mem_ready) begin
          state_d = S_RESP;
          if (gnt_if_q) if_rdata_d = mem_rdata;
          else          dm_rdata_d = mem_rdata;
        end else if (to_q == TO_W'(TIMEOUT - 1)) begin
          // Abort: fetch gets a NOP so the pipeline keeps flowing.
          state_d = S_RESP;
          err_d   = 1'b1;
          if (gnt_if_q) if_rdata_d = FETCH_ERR_DATA;
          else          dm_rdata_d = '0;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      // Requester inputs are stale here, so no grant is taken.
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      gnt_if_q   <= 1'b0;
      err_q      <= 1'b0;
      to_q       <= '0;
      starve_q   <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= 4'h0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_if_q   <= gnt_if_d;
      err_q      <= err_d;
      to_q       <= to_d;
      starve_q   <= starve_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign mem_valid = (state_q == S_FETCH) || (state_q == S_DATA);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign if_ready  = (state_q == S_RESP) && gnt_if_q;
  assign dm_ready  = (state_q == S_RESP) && !gnt_if_q;
  assign bus_err   = (state_q == S_RESP) && err_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = dm_req & ~dm_ready;

endmodule
